// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: three-stage pipelined unsigned multiplier built from
// recursive 2x2 Vedic (Urdhva-Tiryakbhyam) cells.
//   S1 registers the operands, S2 registers the four half-width sub-products,
//   and S3 registers the recombined 2*WIDTH-bit product.
// A single advance enable (adv = !out_valid || out_ready) moves every stage
// together, so a stalled output freezes the whole pipe.
// Optional feature: define VEDIC_SIGNED_EN to add an is_signed input. When
// is_signed is high, S1 stores operand magnitudes plus the result sign, and
// S3 negates the sum. Latency is the same either way.

// 2x2 Vedic cell: vertical and crosswise partial products, folded with two half adders.
module vedic_cell2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_a1b0;
  logic cross_a0b1;
  logic vert_hi;
  logic carry1;

  assign cross_a1b0 = a[1] & b[0];
  assign cross_a0b1 = a[0] & b[1];
  assign vert_hi    = a[1] & b[1];

  // Bit 0 is the low vertical product.
  assign p[0] = a[0] & b[0];

  // First half adder sums the two crosswise terms.
  assign p[1]   = cross_a1b0 ^ cross_a0b1;
  assign carry1 = cross_a1b0 & cross_a0b1;

  // Second half adder folds the carry into the high vertical term.
  assign p[2] = vert_hi ^ carry1;
  assign p[3] = vert_hi & carry1;
endmodule

// Recursive NxN Vedic multiplier. It splits into four (N/2)x(N/2) products
// and stops at the 2x2 cell. N must be a power of two, 2 or larger.
module vedic_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  genvar gi;

  generate
    if (N == 2) begin : g_leaf
      vedic_cell2 u_cell (
        .a (a),
        .b (b),
        .p (p)
      );
    end else begin : g_split
      localparam int H = N / 2;

      // q[0]=aL*bL, q[1]=aH*bL, q[2]=aL*bH, q[3]=aH*bH
      logic [3:0][N-1:0] q;
      logic [N:0]        mid;

      for (gi = 0; gi < 4; gi++) begin : g_sub
        vedic_mul #(.N(H)) u_sub (
          .a (a[(gi % 2) * H +: H]),
          .b (b[(gi / 2) * H +: H]),
          .p (q[gi])
        );
      end

      // Both crosswise products carry the same weight, so add them first.
      assign mid = {1'b0, q[1]} + {1'b0, q[2]};
      assign p   = {{N{1'b0}}, q[0]}
                 + ({{(N-1){1'b0}}, mid} << H)
                 + {q[3], {N{1'b0}}};
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int H = WIDTH / 2;

  genvar gi;

  logic                   adv;
  logic                   v1_reg;
  logic                   v2_reg;
  logic                   v3_reg;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [3:0][WIDTH-1:0]  sub_comb;
  logic [3:0][WIDTH-1:0]  pp_reg;
  logic [WIDTH:0]         mid_sum;
  logic [2*WIDTH-1:0]     sum_mag;
  logic [2*WIDTH-1:0]     sum_final;
  logic [2*WIDTH-1:0]     product_reg;

  // Every stage moves on the same enable, so the pipe never needs skid buffers.
  assign adv       = !v3_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_reg;
  assign product   = product_reg;

`ifdef VEDIC_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic sign_in;
  logic sign1_reg;
  logic sign2_reg;

  // Convert signed operands to magnitudes. -2^(WIDTH-1) maps onto itself,
  // and that value is still the correct unsigned magnitude.
  always_comb begin
    a_mag   = a;
    b_mag   = b;
    sign_in = 1'b0;
    if (is_signed) begin
      if (a[WIDTH-1]) a_mag = ~a + ONE_W;
      if (b[WIDTH-1]) b_mag = ~b + ONE_W;
      sign_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end

  // Carry the result sign alongside the operand and sub-product stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign1_reg <= 1'b0;
      sign2_reg <= 1'b0;
    end else if (adv) begin
      if (in_valid) sign1_reg <= sign_in;
      if (v1_reg)   sign2_reg <= sign1_reg;
    end
  end
`else
  // Unsigned build: operands pass straight through to S1.
  always_comb begin
    a_mag = a;
    b_mag = b;
  end
`endif

  // S1: capture operands on a transfer; an empty slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
    end else if (adv) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        a_reg <= a_mag;
        b_reg <= b_mag;
      end
    end
  end

  // Four half-width Vedic multipliers fed from the S1 operands.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      vedic_mul #(.N(H)) u_pp (
        .a (a_reg[(gi % 2) * H +: H]),
        .b (b_reg[(gi / 2) * H +: H]),
        .p (sub_comb[gi])
      );
    end
  endgenerate

  // S2: register the four sub-products behind a valid S1 slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_reg <= 1'b0;
      pp_reg <= '0;
    end else if (adv) begin
      v2_reg <= v1_reg;
      if (v1_reg) pp_reg <= sub_comb;
    end
  end

  // Combine the four sub-products into the full 2*WIDTH-bit result, with no truncation.
  always_comb begin
    mid_sum = {1'b0, pp_reg[1]} + {1'b0, pp_reg[2]};
    sum_mag = {{WIDTH{1'b0}}, pp_reg[0]}
            + ({{(WIDTH-1){1'b0}}, mid_sum} << H)
            + {pp_reg[3], {WIDTH{1'b0}}};
`ifdef VEDIC_SIGNED_EN
    sum_final = sign2_reg ? (~sum_mag + {{(2*WIDTH-1){1'b0}}, 1'b1}) : sum_mag;
`else
    sum_final = sum_mag;
`endif
  end

  // S3: output register. It holds while the consumer stalls, and bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_reg      <= 1'b0;
      product_reg <= '0;
    end else if (adv) begin
      v3_reg <= v2_reg;
      if (v2_reg) product_reg <= sum_final;
    end
  end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Testbench for vedic_mult_pipe: a 16-bit instance and an 8-bit instance.
// The reference model is plain integer multiplication with an expected-result queue.
// Define VEDIC_SIGNED_EN to add the signed-operand scenarios.
module tb_vedic_mult_pipe;
  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        sg16;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
`ifdef VEDIC_SIGNED_EN
  logic        sg8;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          acc_cyc_q[$];
  int          got_cyc_q[$];

  vedic_mult_pipe #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
`ifdef VEDIC_SIGNED_EN
    .is_signed (sg16),
`endif
    .out_valid (ov16),
    .out_ready (or16),
    .product   (p16)
  );

  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
`ifdef VEDIC_SIGNED_EN
    .is_signed (sg8),
`endif
    .out_valid (ov8),
    .out_ready (or8),
    .product   (p8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the full-width arithmetic product.
  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({48'd0, x});
      sy = longint'({48'd0, y});
    end
    return 32'(sx * sy);
  endfunction

`ifdef VEDIC_SIGNED_EN
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({56'd0, x});
      sy = longint'({56'd0, y});
    end
    return 16'(sx * sy);
  endfunction
`endif

  task automatic drive16(input logic v, input logic [15:0] x, input logic [15:0] y, input logic ordy);
    iv16 = v;
    a16  = x;
    b16  = y;
    or16 = ordy;
    #1;
  endtask

  // Record this cycle's handshakes into the model and observation queues, then advance one clock.
  task automatic step16();
    if (iv16 && ir16) begin
      exp_q.push_back(ref16(a16, b16, sg16));
      acc_cyc_q.push_back(cyc);
    end
    if (ov16 && or16) begin
      got_q.push_back(p16);
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive16(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_ov16 got=%b want=0", ov16); end
    total++; if (p16 !== 32'h0) begin bad++; $display("FAIL reset_p16 got=%h want=0", p16); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_ov8 got=%b want=0", ov8); end
    total++; if (p8 !== 16'h0) begin bad++; $display("FAIL reset_p8 got=%h want=0", p8); end
    rst_n = 1'b1;
    step16();
    total++; if (ir16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir16); end
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_idle_ov got=%b want=0", ov16); end
    $display("test_reset: done");
  endtask

  task automatic test_vectors();
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic [31:0] want[4];
    va   = '{16'hFFFF, 16'h1234, 16'h0000, 16'h0001};
    vb   = '{16'hFFFF, 16'h0010, 16'hABCD, 16'h0001};
    want = '{32'hFFFE0001, 32'h00012340, 32'h00000000, 32'h00000001};
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      drive16(1'b1, va[i], vb[i], 1'b1);
      step16();
    end
    drive16(1'b0, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 10 && got_q.size() < 4; k++) step16();
    total++;
    if (got_q.size() != 4) begin
      bad++; $display("FAIL vec_count got=%0d want=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i] !== want[i]) begin bad++; $display("FAIL vec%0d_product got=%h want=%h", i, got_q[i], want[i]); end
        total++;
        if (got_cyc_q[i] - acc_cyc_q[i] != 3) begin bad++; $display("FAIL vec%0d_latency got=%0d want=3", i, got_cyc_q[i] - acc_cyc_q[i]); end
        if (i > 0) begin
          total++;
          if (got_cyc_q[i] != got_cyc_q[i-1] + 1) begin bad++; $display("FAIL vec%0d_consecutive gap=%0d want=1", i, got_cyc_q[i] - got_cyc_q[i-1]); end
        end
        $display("vector %0d: %h x %h -> %h", i, va[i], vb[i], got_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    clear_queues();
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      step16();
    end
    drive16(1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      total++; if (ir16 !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready got=%b want=0", k, ir16); end
      total++; if (ov16 !== 1'b1) begin bad++; $display("FAIL stall%0d_out_valid got=%b want=1", k, ov16); end
      total++; if (p16 !== exp_q[0]) begin bad++; $display("FAIL stall%0d_product got=%h want=%h", k, p16, exp_q[0]); end
      step16();
    end
    drive16(1'b0, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 10 && got_q.size() < 3; k++) step16();
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL stall_count got=%0d want=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_order%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        if (i > 0) begin
          total++;
          if (got_cyc_q[i] != got_cyc_q[i-1] + 1) begin bad++; $display("FAIL stall_drain%0d gap=%0d want=1", i, got_cyc_q[i] - got_cyc_q[i-1]); end
        end
      end
    end
    $display("test_stall: drained %0d results", got_q.size());
  endtask

  task automatic test_random();
    logic [15:0] corners[4];
    logic [15:0] x, y;
    int n;
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
    clear_queues();
    for (int c = 0; c < 300; c++) begin
      x = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      y = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
`ifdef VEDIC_SIGNED_EN
      sg16 = 1'($urandom_range(0, 1));
`endif
      drive16($urandom_range(0, 9) < 7, x, y, $urandom_range(0, 9) < 6);
      step16();
    end
    sg16 = 1'b0;
    drive16(1'b0, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step16();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_product got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_random: %0d results compared", n);
  endtask

  task automatic test_reset_mid();
    clear_queues();
    for (int i = 0; i < 2; i++) begin
      drive16(1'b1, 16'($urandom) | 16'h0101, 16'($urandom) | 16'h0101, 1'b1);
      step16();
    end
    rst_n = 1'b0;
    drive16(1'b0, 16'h0, 16'h0, 1'b1);
    step16();
    rst_n = 1'b1;
    exp_q.delete();
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", ov16); end
    total++; if (p16 !== 32'h0) begin bad++; $display("FAIL midrst_product got=%h want=0", p16); end
    for (int k = 0; k < 8; k++) step16();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_emitted got=%0d want=0", got_q.size()); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_edge8();
    int first;
    int highs;
    logic [15:0] seen;
    first = -1;
    highs = 0;
    seen  = 16'h0;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; or8 = 1'b1;
    #1;
    total++; if (ir8 !== 1'b1) begin bad++; $display("FAIL edge8_in_ready got=%b want=1", ir8); end
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (ov8) begin
        highs++;
        if (first < 0) begin first = k; seen = p8; end
      end
      @(posedge clk);
      #1;
    end
    total++; if (first != 3) begin bad++; $display("FAIL edge8_latency got=%0d want=3", first); end
    total++; if (seen !== 16'hFE01) begin bad++; $display("FAIL edge8_product got=%h want=fe01", seen); end
    total++; if (highs != 1) begin bad++; $display("FAIL edge8_pulses got=%0d want=1", highs); end
    $display("test_edge8: ff x ff -> %h after %0d cycles", seen, first);
  endtask

`ifdef VEDIC_SIGNED_EN
  task automatic test_signed();
    logic [7:0]  xa[24];
    logic [7:0]  xb[24];
    logic        xs[24];
    logic [15:0] got8[$];
    xa[0] = 8'h80; xb[0] = 8'h7F; xs[0] = 1'b1;
    xa[1] = 8'h80; xb[1] = 8'h7F; xs[1] = 1'b0;
    xa[2] = 8'h80; xb[2] = 8'h80; xs[2] = 1'b1;
    for (int i = 3; i < 24; i++) begin
      xa[i] = 8'($urandom);
      xb[i] = 8'($urandom);
      xs[i] = 1'($urandom_range(0, 1));
    end
    or8 = 1'b1;
    for (int c = 0; c < 34; c++) begin
      iv8 = (c < 24);
      a8  = (c < 24) ? xa[c] : 8'h0;
      b8  = (c < 24) ? xb[c] : 8'h0;
      sg8 = (c < 24) ? xs[c] : 1'b0;
      #1;
      if (ov8) got8.push_back(p8);
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    total++;
    if (got8.size() != 24) begin
      bad++; $display("FAIL signed_count got=%0d want=24", got8.size());
    end else begin
      total++; if (got8[0] !== 16'hC080) begin bad++; $display("FAIL signed_80x7f got=%h want=c080", got8[0]); end
      total++; if (got8[1] !== 16'h3F80) begin bad++; $display("FAIL unsigned_80x7f got=%h want=3f80", got8[1]); end
      for (int i = 2; i < 24; i++) begin
        total++;
        if (got8[i] !== ref8(xa[i], xb[i], xs[i])) begin
          bad++; $display("FAIL signed%0d got=%h want=%h", i, got8[i], ref8(xa[i], xb[i], xs[i]));
        end
      end
    end
    $display("test_signed: %0d results", got8.size());
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0; or16 = 1'b0; sg16 = 1'b0;
    iv8  = 1'b0; a8  = 8'h0;  b8  = 8'h0;  or8  = 1'b0;
`ifdef VEDIC_SIGNED_EN
    sg8 = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_stall();
    test_random();
    test_reset_mid();
    test_edge8();
`ifdef VEDIC_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
